chan_mux_scan: RTL and testbench

//  Parametrised NUM_CH-to-1 multiplexer with a registered output, WIDTH bits per channel.

---
 rtl/chan_mux_scan_if.sv | 42 ++++
 rtl/chan_mux_scan.sv | 130 +++++++++++++
 tb/tb_chan_mux_scan.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/chan_mux_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : chan_mux_scan_if
//  Purpose  : Bundles the data/control signals of chan_mux_scan.
//             master : drives din/mode/sel_in/sel_load, observes the outputs
//             slave  : the multiplexer itself
//  Signals  : din      NUM_CH*WIDTH  channel k at din[k*WIDTH +: WIDTH]
//             mode     2             00 MANUAL, 01 SCAN, 10/11 HOLD
//             sel_in   SELW          requested channel index
//             sel_load 1             strobe to load sel_in (MANUAL only)
//             dout     WIDTH         registered selected channel data
//             cur_sel  SELW          current channel index
//             tick     1             pulse on each scan step
//             sel_err  1             pulse on a rejected sel_in
//  Revision : 1.0  initial release
// ============================================================================
interface chan_mux_scan_if #(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 2
) ();
    localparam int SELW = $clog2(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] din;
    logic [1:0]              mode;
    logic [SELW-1:0]         sel_in;
    logic                    sel_load;
    logic [WIDTH-1:0]        dout;
    logic [SELW-1:0]         cur_sel;
    logic                    tick;
    logic                    sel_err;

    modport master (
        output din, mode, sel_in, sel_load,
        input  dout, cur_sel, tick, sel_err
    );

    modport slave (
        input  din, mode, sel_in, sel_load,
        output dout, cur_sel, tick, sel_err
    );
endinterface
`default_nettype wire

// File: rtl/chan_mux_scan.sv
`default_nettype none
// ============================================================================
//  Module   : chan_mux_scan
//  Purpose  : NUM_CH-to-1 multiplexer, WIDTH bits per channel, registered
//             output. Channel selection by manual load, timed round-robin
//             scan, or hold (everything frozen).
//  Ports    : clk    system clock, rising edge
//             rst_n  asynchronous active-low reset
//             bus    chan_mux_scan_if.slave (din, mode, sel_in, sel_load,
//                    dout, cur_sel, tick, sel_err)
//  Revision : 1.0  initial release
// ============================================================================
module chan_mux_scan #(
    parameter int WIDTH    = 4,
    parameter int NUM_CH   = 2,
    parameter int SCAN_DIV = 25000000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    chan_mux_scan_if.slave   bus
);
    localparam int SELW = $clog2(NUM_CH);
    localparam int CNTW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [SELW-1:0] c_last_ch   = SELW'(NUM_CH - 1);
    localparam logic [SELW:0]   c_num_ch    = (SELW + 1)'(NUM_CH);
    localparam logic [CNTW-1:0] c_cnt_last  = CNTW'(SCAN_DIV - 1);
    localparam logic [1:0]      c_mode_man  = 2'b00;
    localparam logic [1:0]      c_mode_scan = 2'b01;

    // Channel table padded to a power of two so any index value is legal;
    // padding entries are never selected because cur_sel stays < NUM_CH.
    logic [WIDTH-1:0] w_ch [2**SELW];

    generate
        for (genvar k = 0; k < 2**SELW; k++) begin : g_ch
            if (k < NUM_CH) begin : g_real
                assign w_ch[k] = bus.din[k*WIDTH +: WIDTH];
            end else begin : g_pad
                assign w_ch[k] = '0;
            end
        end
    endgenerate

    logic [WIDTH-1:0] r_dout;
    logic [SELW-1:0]  r_cur_sel;
    logic             r_tick;
    logic             r_sel_err;
    logic [CNTW-1:0]  r_cnt;
    logic             r_in_scan;   // previous edge was taken in SCAN

    logic             w_hold;
    logic             w_manual;
    logic             w_scan;
    logic             w_sel_ok;
    logic [CNTW-1:0]  w_cnt_eff;
    logic             w_step;
    logic [WIDTH-1:0] w_dout_nx;
    logic [SELW-1:0]  w_sel_nx;
    logic [CNTW-1:0]  w_cnt_nx;
    logic             w_tick_nx;
    logic             w_err_nx;

    assign w_hold   = bus.mode[1];
    assign w_manual = (bus.mode == c_mode_man);
    assign w_scan   = (bus.mode == c_mode_scan);
    assign w_sel_ok = ({1'b0, bus.sel_in} < c_num_ch);

    // A fresh entry into SCAN (from MANUAL, HOLD or reset) counts from zero
    // regardless of what a frozen HOLD left in the prescaler.
    assign w_cnt_eff = r_in_scan ? r_cnt : '0;
    assign w_step    = w_scan && (w_cnt_eff == c_cnt_last);

    always_comb begin
        w_dout_nx = r_dout;
        w_sel_nx  = r_cur_sel;
        w_cnt_nx  = r_cnt;
        w_tick_nx = 1'b0;
        w_err_nx  = 1'b0;

        // Data path uses the pre-edge index, so an index change reaches
        // dout one cycle after cur_sel moves.
        if (!w_hold) begin
            w_dout_nx = w_ch[r_cur_sel];
        end

        if (w_manual) begin
            w_cnt_nx = '0;
            if (bus.sel_load) begin
                if (w_sel_ok) begin
                    w_sel_nx = bus.sel_in;
                end else begin
                    w_err_nx = 1'b1;
                end
            end
        end else if (w_scan) begin
            if (w_step) begin
                w_cnt_nx  = '0;
                w_tick_nx = 1'b1;
                w_sel_nx  = (r_cur_sel == c_last_ch) ? '0 : r_cur_sel + 1'b1;
            end else begin
                w_cnt_nx  = w_cnt_eff + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout    <= '0;
            r_cur_sel <= '0;
            r_tick    <= 1'b0;
            r_sel_err <= 1'b0;
            r_cnt     <= '0;
            r_in_scan <= 1'b0;
        end else begin
            r_dout    <= w_dout_nx;
            r_cur_sel <= w_sel_nx;
            r_tick    <= w_tick_nx;
            r_sel_err <= w_err_nx;
            r_cnt     <= w_cnt_nx;
            r_in_scan <= w_scan;
        end
    end

    assign bus.dout    = r_dout;
    assign bus.cur_sel = r_cur_sel;
    assign bus.tick    = r_tick;
    assign bus.sel_err = r_sel_err;
endmodule
`default_nettype wire

// File: tb/tb_chan_mux_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chan_mux_scan
//  Purpose  : Self-checking bench for chan_mux_scan. Three instances:
//             0: NUM_CH=4 SCAN_DIV=3, 1: NUM_CH=3 SCAN_DIV=3,
//             2: NUM_CH=4 SCAN_DIV=1. A behavioural model tracks each one
//             and is compared on every falling edge; directed sequences add
//             hand-computed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_chan_mux_scan;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_n;
    logic [15:0] din_v    [3];
    logic [1:0]  mode_v   [3];
    logic [1:0]  sel_in_v [3];
    logic        load_v   [3];
    logic [3:0]  o_dout   [3];
    logic [1:0]  o_sel    [3];
    logic        o_tick   [3];
    logic        o_err    [3];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    chan_mux_scan_if #(.WIDTH(4), .NUM_CH(4)) ifa ();
    chan_mux_scan_if #(.WIDTH(4), .NUM_CH(3)) ifb ();
    chan_mux_scan_if #(.WIDTH(4), .NUM_CH(4)) ifc ();

    assign ifa.din = din_v[0];  assign ifa.mode = mode_v[0];
    assign ifa.sel_in = sel_in_v[0];  assign ifa.sel_load = load_v[0];
    assign ifb.din = din_v[1][11:0];  assign ifb.mode = mode_v[1];
    assign ifb.sel_in = sel_in_v[1];  assign ifb.sel_load = load_v[1];
    assign ifc.din = din_v[2];  assign ifc.mode = mode_v[2];
    assign ifc.sel_in = sel_in_v[2];  assign ifc.sel_load = load_v[2];

    assign o_dout[0] = ifa.dout;  assign o_sel[0] = ifa.cur_sel;
    assign o_tick[0] = ifa.tick;  assign o_err[0] = ifa.sel_err;
    assign o_dout[1] = ifb.dout;  assign o_sel[1] = ifb.cur_sel;
    assign o_tick[1] = ifb.tick;  assign o_err[1] = ifb.sel_err;
    assign o_dout[2] = ifc.dout;  assign o_sel[2] = ifc.cur_sel;
    assign o_tick[2] = ifc.tick;  assign o_err[2] = ifc.sel_err;

    chan_mux_scan #(.WIDTH(4), .NUM_CH(4), .SCAN_DIV(3)) dut_a (
        .clk(clk), .rst_n(rst_n[0]), .bus(ifa));
    chan_mux_scan #(.WIDTH(4), .NUM_CH(3), .SCAN_DIV(3)) dut_b (
        .clk(clk), .rst_n(rst_n[1]), .bus(ifb));
    chan_mux_scan #(.WIDTH(4), .NUM_CH(4), .SCAN_DIV(1)) dut_c (
        .clk(clk), .rst_n(rst_n[2]), .bus(ifc));

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_run counts edges spent in SCAN since entry; a step happens whenever
    // that count is a multiple of the divider.
    int         nch [3] = '{4, 3, 4};
    int         div [3] = '{3, 3, 1};
    int         m_sel  [3];
    logic [3:0] m_dout [3];
    bit         m_tick [3];
    bit         m_err  [3];
    int         m_run  [3];

    function automatic logic [3:0] chan(input logic [15:0] d, input int s);
        logic [15:0] t;
        t = d >> (4 * s);
        return t[3:0];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n[i]) begin
                m_sel[i] = 0; m_dout[i] = 4'h0; m_tick[i] = 0;
                m_err[i] = 0; m_run[i] = 0;
            end else if (mode_v[i][1]) begin
                m_tick[i] = 0; m_err[i] = 0; m_run[i] = 0;
            end else begin
                m_dout[i] = chan(din_v[i], m_sel[i]);
                m_tick[i] = 0;
                m_err[i]  = 0;
                if (mode_v[i] == 2'b00) begin
                    m_run[i] = 0;
                    if (load_v[i]) begin
                        if (int'(sel_in_v[i]) < nch[i]) m_sel[i] = int'(sel_in_v[i]);
                        else m_err[i] = 1;
                    end
                end else begin
                    m_run[i]++;
                    if (m_run[i] % div[i] == 0) begin
                        m_tick[i] = 1;
                        m_sel[i]  = (m_sel[i] + 1) % nch[i];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                if (!rst_n[i]) begin
                    chk($sformatf("rst_dout%0d", i), int'(o_dout[i]), 0);
                    chk($sformatf("rst_sel%0d", i),  int'(o_sel[i]),  0);
                    chk($sformatf("rst_tick%0d", i), int'(o_tick[i]), 0);
                    chk($sformatf("rst_err%0d", i),  int'(o_err[i]),  0);
                end else begin
                    chk($sformatf("dout%0d", i), int'(o_dout[i]), int'(m_dout[i]));
                    chk($sformatf("sel%0d", i),  int'(o_sel[i]),  m_sel[i]);
                    chk($sformatf("tick%0d", i), int'(o_tick[i]), int'(m_tick[i]));
                    chk($sformatf("err%0d", i),  int'(o_err[i]),  int'(m_err[i]));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int         exp_sel3  [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    logic [3:0] exp_dout3 [12] = '{4'h3, 4'h3, 4'h3, 4'hA, 4'hA, 4'hA,
                                   4'h5, 4'h5, 4'h5, 4'hD, 4'hD, 4'hD};
    int         exp_dout6 [5]  = '{3, 10, 5, 13, 3};

    initial begin
        rst_n = 3'b000;
        for (int i = 0; i < 3; i++) begin
            din_v[i] = 16'h0; mode_v[i] = 2'b00; sel_in_v[i] = 2'd0; load_v[i] = 1'b0;
        end
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_dout", int'(o_dout[0]), 0);
        chk("reset_sel",  int'(o_sel[0]),  0);
        @(negedge clk);
        rst_n = 3'b111;

        // 1: manual load of channel 2
        din_v[0] = 16'hD5A3; sel_in_v[0] = 2'd2; load_v[0] = 1'b1;
        @(negedge clk);
        load_v[0] = 1'b0;
        chk("t1_sel", int'(o_sel[0]), 2);
        @(negedge clk);
        chk("t1_dout", int'(o_dout[0]), 5);

        // 2: NUM_CH=3 instance, out-of-range index rejected
        din_v[1] = 16'h05A3; sel_in_v[1] = 2'd1; load_v[1] = 1'b1;
        @(negedge clk);
        load_v[1] = 1'b0;
        @(negedge clk);
        chk("t2_sel_pre", int'(o_sel[1]), 1);
        chk("t2_dout_pre", int'(o_dout[1]), 10);
        sel_in_v[1] = 2'd3; load_v[1] = 1'b1;
        @(negedge clk);
        load_v[1] = 1'b0;
        chk("t2_err_hi", int'(o_err[1]), 1);
        chk("t2_sel_kept", int'(o_sel[1]), 1);
        @(negedge clk);
        chk("t2_err_lo", int'(o_err[1]), 0);
        chk("t2_dout_kept", int'(o_dout[1]), 10);
        mode_v[1] = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 6) chk("t2_scan_wrap", int'(o_sel[1]), 0);
        end
        mode_v[1] = 2'b00;

        // 3: scan from channel 0; sel_load is ignored while scanning
        sel_in_v[0] = 2'd0; load_v[0] = 1'b1;
        @(negedge clk);
        load_v[0] = 1'b1; sel_in_v[0] = 2'd3; mode_v[0] = 2'b01;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("t3_tick_k%0d", k), int'(o_tick[0]), (k % 3 == 0) ? 1 : 0);
            chk($sformatf("t3_sel_k%0d", k), int'(o_sel[0]), exp_sel3[k-1]);
            chk($sformatf("t3_dout_k%0d", k), int'(o_dout[0]), int'(exp_dout3[k-1]));
        end
        load_v[0] = 1'b0;

        // 4: hold freezes dout while din changes
        mode_v[0] = 2'b00; sel_in_v[0] = 2'd2; load_v[0] = 1'b1;
        @(negedge clk);
        load_v[0] = 1'b0;
        @(negedge clk);
        chk("t4_dout_pre", int'(o_dout[0]), 5);
        mode_v[0] = 2'b10;
        @(negedge clk);
        din_v[0] = 16'h0000;
        @(negedge clk);
        chk("t4_hold_a", int'(o_dout[0]), 5);
        mode_v[0] = 2'b11;
        @(negedge clk);
        @(negedge clk);
        chk("t4_hold_b", int'(o_dout[0]), 5);
        mode_v[0] = 2'b00;
        @(negedge clk);
        chk("t4_release", int'(o_dout[0]), 0);

        // 5: asynchronous reset in the middle of a scan count
        din_v[0] = 16'hD5A3; mode_v[0] = 2'b01;
        @(posedge clk);
        #2;
        chk("t5_pre_dout", int'(o_dout[0]), 5);
        rst_n[0] = 1'b0;
        #1;
        chk("t5_async_dout", int'(o_dout[0]), 0);
        chk("t5_async_sel",  int'(o_sel[0]),  0);
        chk("t5_async_tick", int'(o_tick[0]), 0);
        chk("t5_async_err",  int'(o_err[0]),  0);
        @(negedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("t5_tick_k%0d", k), int'(o_tick[0]), (k == 3) ? 1 : 0);
        end
        chk("t5_sel_step", int'(o_sel[0]), 1);
        mode_v[0] = 2'b00;

        // 6: SCAN_DIV=1 steps every cycle, then MANUAL stops it
        din_v[2] = 16'hD5A3; mode_v[2] = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("t6_sel_k%0d", k), int'(o_sel[2]), k % 4);
            chk($sformatf("t6_tick_k%0d", k), int'(o_tick[2]), 1);
            chk($sformatf("t6_dout_k%0d", k), int'(o_dout[2]), exp_dout6[k-1]);
        end
        mode_v[2] = 2'b00;
        @(negedge clk);
        chk("t6_tick_off", int'(o_tick[2]), 0);
        chk("t6_sel_frozen", int'(o_sel[2]), 1);
        chk("t6_dout_man", int'(o_dout[2]), 10);
        @(negedge clk);
        chk("t6_sel_frozen2", int'(o_sel[2]), 1);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
